// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM-macro signal bundle for sram_fifo_ctrl.
// slave = controller side, master = core/SRAM side.
interface sram_fifo_ctrl_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  logic              enq_valid;
  logic              enq_ready;
  logic [WIDTH-1:0]  enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [WIDTH-1:0]  deq_data;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] sram_A1;
  logic              sram_CSB1;
  logic              sram_OEB1;
  logic [WIDTH-1:0]  sram_O1;
  logic [ADDR_W-1:0] sram_A2;
  logic              sram_CSB2;
  logic              sram_WEB2;
  logic [WIDTH-1:0]  sram_I2;

  modport slave (
    input  enq_valid, enq_data, deq_ready, sram_O1,
    output enq_ready, deq_valid, deq_data, count,
    output sram_A1, sram_CSB1, sram_OEB1,
    output sram_A2, sram_CSB2, sram_WEB2, sram_I2
  );

  modport master (
    output enq_valid, enq_data, deq_ready, sram_O1,
    input  enq_ready, deq_valid, deq_data, count,
    input  sram_A1, sram_CSB1, sram_OEB1,
    input  sram_A2, sram_CSB2, sram_WEB2, sram_I2
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a 1R1W SRAM macro with a
// 2-entry skid buffer hiding the registered read port.
module sram_fifo_ctrl #(
  parameter int DEPTH  = 25,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input logic            clock,
  input logic            reset_n,
  sram_fifo_ctrl_if.slave bus
);
  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_sram_cnt;
  logic              r_inflight;
  logic [1:0]        r_ob_cnt;
  logic              r_ob_hd;
  logic              r_ob_tl;
  logic [WIDTH-1:0]  r_ob_mem [2];

  logic              w_enq_ready;
  logic              w_deq_valid;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic [2:0]        w_pend;
  logic              w_issue;
  logic [ADDR_W-1:0] w_wr_nxt;
  logic [ADDR_W-1:0] w_rd_nxt;

  assign w_enq_ready = (r_sram_cnt != CW'(DEPTH));
  assign w_deq_valid = (r_ob_cnt != 2'd0);
  assign w_enq_fire  = bus.enq_valid & w_enq_ready;
  assign w_deq_fire  = w_deq_valid & bus.deq_ready;

  // Slots the buffer will still owe after this cycle's dequeue.
  assign w_pend  = {1'b0, r_ob_cnt}
                 + {2'b0, r_inflight}
                 - {2'b0, w_deq_fire};
  assign w_issue = (r_sram_cnt != '0) & (w_pend < 3'd2);

  assign w_wr_nxt = (r_wr_ptr == ADDR_W'(DEPTH - 1))
                  ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == ADDR_W'(DEPTH - 1))
                  ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_ob_hd    <= 1'b0;
      r_ob_tl    <= 1'b0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= w_wr_nxt;
      if (w_issue)    r_rd_ptr <= w_rd_nxt;
      case ({w_enq_fire, w_issue})
        2'b10:   r_sram_cnt <= r_sram_cnt + 1'b1;
        2'b01:   r_sram_cnt <= r_sram_cnt - 1'b1;
        default: r_sram_cnt <= r_sram_cnt;
      endcase
      r_inflight <= w_issue;
      if (r_inflight) r_ob_tl <= ~r_ob_tl;
      if (w_deq_fire) r_ob_hd <= ~r_ob_hd;
      case ({r_inflight, w_deq_fire})
        2'b10:   r_ob_cnt <= r_ob_cnt + 2'd1;
        2'b01:   r_ob_cnt <= r_ob_cnt - 2'd1;
        default: r_ob_cnt <= r_ob_cnt;
      endcase
    end
  end

  // Payload needs no reset; r_ob_cnt gates visibility.
  always_ff @(posedge clock) begin
    if (r_inflight) r_ob_mem[r_ob_tl] <= bus.sram_O1;
  end

  assign bus.enq_ready = w_enq_ready;
  assign bus.deq_valid = w_deq_valid;
  assign bus.deq_data  = r_ob_mem[r_ob_hd];
  assign bus.count     = r_sram_cnt
                       + CW'(r_inflight)
                       + CW'(r_ob_cnt);
  assign bus.sram_A1   = r_rd_ptr;
  assign bus.sram_CSB1 = ~w_issue;
  assign bus.sram_OEB1 = 1'b0;
  assign bus.sram_A2   = r_wr_ptr;
  assign bus.sram_CSB2 = ~w_enq_fire;
  assign bus.sram_WEB2 = ~w_enq_fire;
  assign bus.sram_I2   = bus.enq_data;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with an SRAM
// model and a queue-based reference FIFO.
module tb_sram_fifo_ctrl;
  localparam int DEPTH = 25;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_fifo_ctrl_if #(.WIDTH(64), .ADDR_W(5)) b ();

  sram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(64), .ADDR_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b)
  );

  logic [63:0] mem [DEPTH];
  always @(posedge clock) begin
    if (!b.sram_CSB2 && !b.sram_WEB2 && b.sram_A2 < 5'(DEPTH))
      mem[b.sram_A2] <= b.sram_I2;
    if (!b.sram_CSB1 && b.sram_A1 < 5'(DEPTH))
      b.sram_O1 <= mem[b.sram_A1];
  end

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] q[$];
  int n_wr, n_rd, n_rx;
  logic last_ef, last_df;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic cyc(input logic ev, input logic [63:0] ed,
                     input logic dr);
    logic [63:0] w;
    @(negedge clock);
    b.enq_valid = ev;
    b.enq_data  = ed;
    b.deq_ready = dr;
    #1;
    chk("count_vs_model", 64'(b.count), 64'(q.size()));
    last_ef = ev & b.enq_ready;
    last_df = b.deq_valid & dr;
    if (ev && !b.enq_ready)
      chk("no_write_when_full", 64'(b.sram_WEB2), 64'd1);
    if (!b.sram_CSB1) begin
      chk("rd_addr", 64'(b.sram_A1), 64'(n_rd % DEPTH));
      n_rd++;
    end
    if (last_df) begin
      if (q.size() == 0) chk("deq_on_empty", 64'd1, 64'd0);
      else begin
        w = q.pop_front();
        chk("deq_data", b.deq_data, w);
      end
      n_rx++;
    end
    if (last_ef) begin
      chk("wr_addr", 64'(b.sram_A2), 64'(n_wr % DEPTH));
      n_wr++;
      q.push_back(ed);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    b.enq_valid = 1'b0;
    b.deq_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_enq_ready", 64'(b.enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(b.deq_valid), 64'd0);
    chk("rst_csb1", 64'(b.sram_CSB1), 64'd1);
    chk("rst_csb2", 64'(b.sram_CSB2), 64'd1);
    chk("rst_web2", 64'(b.sram_WEB2), 64'd1);
    chk("rst_count", 64'(b.count), 64'd0);
    chk("rst_oeb1", 64'(b.sram_OEB1), 64'd0);
    q.delete();
    n_wr = 0;
    n_rd = 0;
    n_rx = 0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ev;
    logic [63:0] ed;
    logic        dr;
    logic [5:0]  e_cnt;
    logic        e_dv;
    logic [63:0] e_dat;
    logic        e_csb1;
    logic [4:0]  e_a1;
    logic        e_web2;
    logic [4:0]  e_a2;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic [63:0] D;
    int sent, rx0, r0, guard, w24;
    bit started;
    logic ev, dr;

    D = 64'hDEADBEEF00000001;
    vt[0] = '{1'b1, D,     1'b1, 6'd0, 1'b0, 64'd0, 1'b1, 5'd0, 1'b0, 5'd0};
    vt[1] = '{1'b0, 64'd0, 1'b1, 6'd1, 1'b0, 64'd0, 1'b0, 5'd0, 1'b1, 5'd0};
    vt[2] = '{1'b0, 64'd0, 1'b1, 6'd1, 1'b0, 64'd0, 1'b1, 5'd0, 1'b1, 5'd0};
    vt[3] = '{1'b0, 64'd0, 1'b1, 6'd1, 1'b1, D,     1'b1, 5'd0, 1'b1, 5'd0};
    vt[4] = '{1'b0, 64'd0, 1'b1, 6'd0, 1'b0, 64'd0, 1'b1, 5'd0, 1'b1, 5'd0};

    b.enq_valid = 1'b0;
    b.enq_data  = '0;
    b.deq_ready = 1'b0;
    last_ef = 1'b0;
    last_df = 1'b0;

    // single word through an empty FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(vt[i].ev, vt[i].ed, vt[i].dr);
      chk("vec_count", 64'(b.count), 64'(vt[i].e_cnt));
      chk("vec_deq_valid", 64'(b.deq_valid), 64'(vt[i].e_dv));
      chk("vec_csb1", 64'(b.sram_CSB1), 64'(vt[i].e_csb1));
      chk("vec_web2", 64'(b.sram_WEB2), 64'(vt[i].e_web2));
      if (vt[i].e_dv)
        chk("vec_data", b.deq_data, vt[i].e_dat);
      if (!vt[i].e_csb1)
        chk("vec_a1", 64'(b.sram_A1), 64'(vt[i].e_a1));
      if (!vt[i].e_web2)
        chk("vec_a2", 64'(b.sram_A2), 64'(vt[i].e_a2));
    end

    // fill with consumer stalled
    do_reset();
    sent = 0;
    for (int i = 0; i < 35; i++) begin
      cyc(1'b1, 64'(sent), 1'b0);
      if (last_ef) sent++;
    end
    cyc(1'b0, 64'd0, 1'b0);
    chk("fill_accepted", 64'(sent), 64'd27);
    chk("fill_count", 64'(b.count), 64'd27);
    chk("fill_enq_ready", 64'(b.enq_ready), 64'd0);
    for (int i = 0; i < 30; i++) begin
      r0 = n_rx;
      cyc(1'b0, 64'd0, 1'b1);
      if (i == 0) begin
        chk("drain_ready0", 64'(b.enq_ready), 64'd0);
        chk("drain_issue0", 64'(b.sram_CSB1), 64'd0);
      end
      if (i == 1)
        chk("drain_ready1", 64'(b.enq_ready), 64'd1);
      if (r0 < 27)
        chk("drain_nobubble", 64'(b.deq_valid), 64'd1);
    end
    chk("drain_all", 64'(n_rx), 64'd27);

    // wrap-around streaming
    do_reset();
    sent = 0;
    rx0 = n_rx;
    guard = 0;
    started = 0;
    w24 = 0;
    while ((sent < 60 || n_rx - rx0 < 60) && guard < 300) begin
      r0 = n_rx;
      cyc(sent < 60, 64'(sent), 1'b1);
      if (last_ef) sent++;
      if (!b.sram_CSB1 && b.sram_A1 == 5'd24) w24++;
      if (started && r0 - rx0 < 60)
        chk("wrap_nobubble", 64'(b.deq_valid), 64'd1);
      if (b.deq_valid) started = 1;
      guard++;
    end
    chk("wrap_done", 64'(n_rx - rx0), 64'd60);
    chk("wrap_a1_24", 64'(w24), 64'd2);
    chk("wrap_wrcnt", 64'(n_wr), 64'd60);

    // random backpressure
    do_reset();
    sent = 0;
    guard = 0;
    while ((sent < 200 || n_rx < 200) && guard < 3000) begin
      ev = (sent < 200) && ($urandom_range(0, 99) < 70);
      dr = 1'($urandom_range(0, 1));
      cyc(ev, {$urandom, $urandom}, dr);
      if (last_ef) sent++;
      chk("cnt_max", 64'(b.count <= 6'd27), 64'd1);
      guard++;
    end
    chk("rand_rx", 64'(n_rx), 64'd200);
    chk("rand_empty", 64'(q.size()), 64'd0);

    // reset with a read in flight
    do_reset();
    for (int i = 0; i < 11; i++) cyc(1'b1, 64'(100 + i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1);
    chk("mid_issue", 64'(b.sram_CSB1), 64'd0);
    chk("mid_deq", 64'(last_df), 64'd1);
    do_reset();
    cyc(1'b1, 64'h5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'd0, 1'b1);
      if (i < 2)
        chk("post_rst_empty", 64'(b.deq_valid), 64'd0);
      else begin
        chk("post_rst_valid", 64'(b.deq_valid), 64'd1);
        chk("post_rst_data", b.deq_data, 64'h5);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
